// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_ctrl
// Purpose  : Reset sequencer and run monitor.
//            - Asserts reset asynchronously and releases it synchronously.
//            - Holds reset for HOLD_CYCLES cycles.
//            - Releases N_STAGE reset domains in order, STAGE_GAP cycles
//              apart (stage 0 first).
//            - In RUN, counts cycles and raises a sticky timeout flag.
//            - Accepts a soft reset request that restarts from HOLD.
// Ports    : clk_in        - system clock, rising edge
//            rst_in        - asynchronous active-high reset
//            soft_rst_req  - level request, sampled only in RUN
//            stage_rst_out - per-domain active-high reset, bit i = stage i
//            rdy_out       - all stages released and sequencer in RUN
//            seq_busy      - high in every state except RUN
//            cycle_cnt     - saturating count of RUN cycles
//            timeout       - sticky, set when cycle_cnt reaches TIMEOUT
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl #(
  parameter int              N_STAGE     = 3,
  parameter int              HOLD_CYCLES = 25,
  parameter int              STAGE_GAP   = 4,
  parameter int              SYNC_STAGES = 2,
  parameter int              CNT_W       = 32,
  parameter longint unsigned TIMEOUT     = 150000000
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               soft_rst_req,
  output logic [N_STAGE-1:0] stage_rst_out,
  output logic               rdy_out,
  output logic               seq_busy,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic               timeout
);

  // Sequence counter value (counted from HOLD entry) at which RUN is entered:
  // one edge after the last stage release.
  localparam int c_SEQ_LEN = HOLD_CYCLES + (N_STAGE - 1) * STAGE_GAP + 1;

  localparam longint unsigned c_CNT_MAX =
      (CNT_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_W) - 64'd1);

  // A threshold beyond the counter range can never be reached, so the flag
  // is disabled outright rather than compared against a truncated value.
  localparam bit              c_TO_EN  = (TIMEOUT != 64'd0) && (TIMEOUT <= c_CNT_MAX);
  localparam logic [CNT_W-1:0] c_TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t                 state_q,     state_d;
  logic [SYNC_STAGES-1:0] sync_q,      sync_d;
  logic [31:0]            seq_cnt_q,   seq_cnt_d;
  logic [N_STAGE-1:0]     stage_q,     stage_d;
  logic                   rdy_q,       rdy_d;
  logic                   busy_q,      busy_d;
  logic [CNT_W-1:0]       cycle_cnt_q, cycle_cnt_d;
  logic                   timeout_q,   timeout_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_SYNC;
      sync_q      <= '1;
      seq_cnt_q   <= '0;
      stage_q     <= '1;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b1;
      cycle_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      seq_cnt_q   <= seq_cnt_d;
      stage_q     <= stage_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
      cycle_cnt_q <= cycle_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], 1'b0};
    seq_cnt_d   = seq_cnt_q;
    stage_d     = stage_q;
    cycle_cnt_d = cycle_cnt_q;
    timeout_d   = timeout_q;

    case (state_q)
      ST_SYNC: begin
        // Leave SYNC on the edge where the synchronised release reaches the
        // output of the chain.
        if (sync_q[SYNC_STAGES-1] && !sync_d[SYNC_STAGES-1]) begin
          state_d = ST_HOLD;
        end
      end

      ST_HOLD, ST_RELEASE: begin
        seq_cnt_d = seq_cnt_q + 32'd1;
        // Each stage clears exactly once at its own count; nothing in this
        // branch ever sets a bit, so release is monotonic.
        for (int i = 0; i < N_STAGE; i++) begin
          if (seq_cnt_d == 32'(HOLD_CYCLES + i * STAGE_GAP)) begin
            stage_d[i] = 1'b0;
          end
        end
        if ((state_q == ST_HOLD) && (seq_cnt_d == 32'(HOLD_CYCLES))) begin
          state_d = ST_RELEASE;
        end
        // With a single stage, RELEASE lasts just the one settling edge.
        if (seq_cnt_d == 32'(c_SEQ_LEN)) begin
          state_d   = ST_RUN;
          seq_cnt_d = '0;
        end
      end

      ST_RUN: begin
        if (soft_rst_req) begin
          state_d     = ST_HOLD;
          seq_cnt_d   = '0;
          stage_d     = '1;
          cycle_cnt_d = '0;
          timeout_d   = 1'b0;
        end else begin
          if (cycle_cnt_q != {CNT_W{1'b1}}) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
          end
          if (c_TO_EN && (cycle_cnt_d == c_TO_VAL)) begin
            timeout_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_SYNC;
      end
    endcase

    rdy_d  = (state_d == ST_RUN);
    busy_d = (state_d != ST_RUN);
  end

  assign stage_rst_out = stage_q;
  assign rdy_out       = rdy_q;
  assign seq_busy      = busy_q;
  assign cycle_cnt     = cycle_cnt_q;
  assign timeout       = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq_ctrl
// Purpose  : Directed self-checking bench for rst_seq_ctrl. Three instances:
//            default parameters, a 4-bit counter with TIMEOUT=10, and a
//            single-stage short sequence with timeout disabled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: defaults
  logic        rst_a  = 1'b1;
  logic        soft_a = 1'b0;
  logic [2:0]  stage_a;
  logic        rdy_a, busy_a, to_a;
  logic [31:0] cnt_a;

  // Instance B: CNT_W=4, TIMEOUT=10
  logic        rst_b  = 1'b1;
  logic        soft_b = 1'b0;
  logic [2:0]  stage_b;
  logic        rdy_b, busy_b, to_b;
  logic [3:0]  cnt_b;

  // Instance C: N_STAGE=1, HOLD_CYCLES=1, TIMEOUT=0, CNT_W=4
  logic        rst_c  = 1'b1;
  logic        soft_c = 1'b0;
  logic [0:0]  stage_c;
  logic        rdy_c, busy_c, to_c;
  logic [3:0]  cnt_c;

  rst_seq_ctrl dut_a (
    .clk_in(clk), .rst_in(rst_a), .soft_rst_req(soft_a),
    .stage_rst_out(stage_a), .rdy_out(rdy_a), .seq_busy(busy_a),
    .cycle_cnt(cnt_a), .timeout(to_a)
  );

  rst_seq_ctrl #(.CNT_W(4), .TIMEOUT(10)) dut_b (
    .clk_in(clk), .rst_in(rst_b), .soft_rst_req(soft_b),
    .stage_rst_out(stage_b), .rdy_out(rdy_b), .seq_busy(busy_b),
    .cycle_cnt(cnt_b), .timeout(to_b)
  );

  rst_seq_ctrl #(.N_STAGE(1), .HOLD_CYCLES(1), .STAGE_GAP(4), .SYNC_STAGES(2),
                 .CNT_W(4), .TIMEOUT(0)) dut_c (
    .clk_in(clk), .rst_in(rst_c), .soft_rst_req(soft_c),
    .stage_rst_out(stage_c), .rdy_out(rdy_c), .seq_busy(busy_c),
    .cycle_cnt(cnt_c), .timeout(to_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Default timeline, e = edges since release (or e = k+2 for k edges after
  // a soft reset request). Packs {stage, rdy, busy, cnt[31:0], timeout}.
  function automatic logic [37:0] exp_a(int e);
    logic [2:0]  s;
    logic        r;
    logic [31:0] c;
    s = (e >= 35) ? 3'b000 : (e >= 31) ? 3'b100 : (e >= 27) ? 3'b110 : 3'b111;
    r = (e >= 36);
    c = r ? 32'(e - 36) : 32'd0;
    return {s, r, ~r, c, 1'b0};
  endfunction

  task automatic test_reset();
    logic [37:0] got;
    rst_a = 1'b1;
    repeat (3) step();
    got = {stage_a, rdy_a, busy_a, cnt_a, to_a};
    n_cmp++;
    if (got !== {3'b111, 1'b0, 1'b1, 32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", got, {3'b111, 1'b0, 1'b1, 32'd0, 1'b0});
    end
    rst_a = 1'b0;
    for (int e = 1; e <= 41; e++) begin
      step();
      got = {stage_a, rdy_a, busy_a, cnt_a, to_a};
      n_cmp++;
      if (got !== exp_a(e)) begin
        n_err++;
        $display("FAIL seq_default e=%0d: got %h want %h", e, got, exp_a(e));
      end
    end
  endtask

  task automatic test_async_glitch();
    logic [37:0] got;
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    repeat (30) step();
    got = {stage_a, rdy_a, busy_a, cnt_a, to_a};
    n_cmp++;
    if (got !== exp_a(30)) begin
      n_err++;
      $display("FAIL pre_glitch: got %h want %h", got, exp_a(30));
    end
    rst_a = 1'b1;
    #1;
    got = {stage_a, rdy_a, busy_a, cnt_a, to_a};
    n_cmp++;
    if (got !== {3'b111, 1'b0, 1'b1, 32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL glitch_async: got %h want %h", got, {3'b111, 1'b0, 1'b1, 32'd0, 1'b0});
    end
    #2;
    rst_a = 1'b0;
    for (int e = 1; e <= 37; e++) begin
      step();
      got = {stage_a, rdy_a, busy_a, cnt_a, to_a};
      n_cmp++;
      if (got !== exp_a(e)) begin
        n_err++;
        $display("FAIL glitch_rerun e=%0d: got %h want %h", e, got, exp_a(e));
      end
    end
  endtask

  task automatic test_soft_rst();
    logic [37:0] got;
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    repeat (136) step();
    n_cmp++;
    if (cnt_a !== 32'd100) begin
      n_err++;
      $display("FAIL soft_pre_cnt: got %0d want 100", cnt_a);
    end
    soft_a = 1'b1;
    step();
    soft_a = 1'b0;
    got = {stage_a, rdy_a, busy_a, cnt_a, to_a};
    n_cmp++;
    if (got !== {3'b111, 1'b0, 1'b1, 32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL soft_after_req: got %h want %h", got, {3'b111, 1'b0, 1'b1, 32'd0, 1'b0});
    end
    for (int k = 1; k <= 36; k++) begin
      step();
      got = {stage_a, rdy_a, busy_a, cnt_a, to_a};
      n_cmp++;
      if (got !== exp_a(k + 2)) begin
        n_err++;
        $display("FAIL soft_seq k=%0d: got %h want %h", k, got, exp_a(k + 2));
      end
    end
  endtask

  task automatic test_soft_ignored();
    logic [37:0] got;
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      soft_a = (e >= 5 && e <= 35);
      step();
      got = {stage_a, rdy_a, busy_a, cnt_a, to_a};
      n_cmp++;
      if (got !== exp_a(e)) begin
        n_err++;
        $display("FAIL soft_ignored e=%0d: got %h want %h", e, got, exp_a(e));
      end
    end
    soft_a = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [37:0] got;
    logic [37:0] exp;
    int          pulses;
    pulses = 0;
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    for (int e = 1; e <= 75; e++) begin
      soft_a = (e >= 30);
      step();
      // Held request: every RUN edge restarts, so the timeline repeats with
      // period 35 starting from the reset state after edge 37.
      exp = (e <= 36) ? exp_a(e) : exp_a(((e - 37) % 35) + 2);
      got = {stage_a, rdy_a, busy_a, cnt_a, to_a};
      if (rdy_a === 1'b1) pulses++;
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL back_to_back e=%0d: got %h want %h", e, got, exp);
      end
    end
    soft_a = 1'b0;
    n_cmp++;
    if (pulses !== 2) begin
      n_err++;
      $display("FAIL b2b_rdy_pulses: got %0d want 2", pulses);
    end
  endtask

  task automatic test_timeout();
    logic [9:0] got;
    logic [9:0] exp;
    logic [2:0] s;
    logic       r;
    int         c;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      step();
      s = (e >= 35) ? 3'b000 : (e >= 31) ? 3'b100 : (e >= 27) ? 3'b110 : 3'b111;
      r = (e >= 36);
      c = r ? ((e - 36) > 15 ? 15 : (e - 36)) : 0;
      exp = {s, r, ~r, 4'(c), (r && (e - 36) >= 10)};
      got = {stage_b, rdy_b, busy_b, cnt_b, to_b};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL timeout e=%0d: got %h want %h", e, got, exp);
      end
    end
    soft_b = 1'b1;
    step();
    soft_b = 1'b0;
    got = {stage_b, rdy_b, busy_b, cnt_b, to_b};
    n_cmp++;
    if (got !== {3'b111, 1'b0, 1'b1, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL timeout_soft_clear: got %h want %h", got, {3'b111, 1'b0, 1'b1, 4'd0, 1'b0});
    end
  endtask

  task automatic test_single_stage();
    logic [7:0] got;
    logic [7:0] exp;
    logic       r;
    int         c;
    rst_c = 1'b1;
    step();
    rst_c = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      step();
      r = (e >= 4);
      c = r ? ((e - 4) > 15 ? 15 : (e - 4)) : 0;
      exp = {(e < 3), r, ~r, 4'(c), 1'b0};
      got = {stage_c, rdy_c, busy_c, cnt_c, to_c};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL single_stage e=%0d: got %h want %h", e, got, exp);
      end
    end
  endtask

  initial begin
    rst_b = 1'b1;
    rst_c = 1'b1;
    test_reset();
    test_async_glitch();
    test_soft_rst();
    test_soft_ignored();
    test_back_to_back();
    test_timeout();
    test_single_stage();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
